// File: rtl/router_pkg.sv
// Shared constants and the check-byte combine function for the router datapath.
package router_pkg;

  localparam int CHK_XOR   = 0;
  localparam int CHK_SUM   = 1;
  localparam int CHK_MAX_W = 32;

  // Callers zero-extend into CHK_MAX_W and truncate the result, which gives sum mod 2**DATA_W.
  function automatic logic [CHK_MAX_W-1:0] chk_op(input logic [CHK_MAX_W-1:0] acc,
                                                  input logic [CHK_MAX_W-1:0] b,
                                                  input int                   mode);
    if (mode == CHK_SUM) begin
      return acc + b;
    end
    return acc ^ b;
  endfunction

endpackage

// File: rtl/router_chk_accum.sv
// Running check accumulator over header and payload bytes (XOR or modular sum).
module router_chk_accum
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] byte_in,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = DATA_W'(chk_op(CHK_MAX_W'(acc_q), CHK_MAX_W'(byte_in), CHK_MODE));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/router_pkt_register.sv
// Packet datapath register: latches the header, forwards bytes to the FIFOs,
// replays a byte held across a FIFO-full stall and checks each packet.
module router_pkt_register
  import router_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int N_PORTS  = 3,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic              pkt_vld,
  input  logic              fifo_full,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              low_packet_valid,
  output logic              parity_done,
  output logic              parity_err,
  output logic              len_err,
  output logic              bad_addr,
  output logic              error
);

  localparam int                LEN_W     = DATA_W - ADDR_W;
  localparam logic [LEN_W-1:0]  CNT_MAX   = '1;
  localparam logic [ADDR_W:0]   N_PORTS_W = (ADDR_W+1)'(N_PORTS);

  logic [DATA_W-1:0] header_q, header_d, hold_q, hold_d, pkt_chk_q, pkt_chk_d, dout_q, dout_d;
  logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;
  logic              hold_is_data_q, hold_is_data_d, ovf_q, ovf_d;
  logic              dout_vld_q, dout_vld_d, lpv_q, lpv_d, pd_q, pd_d, pd_dly_q, pd_dly_d;
  logic              perr_q, perr_d, lerr_q, lerr_d, err_q, err_d, bad_addr_q, bad_addr_d;

  logic              lfd_go, ld_go, laf_go, acc_en, cnt_inc, addr_ok;
  logic [DATA_W-1:0] acc_byte, acc;

  // detect_add overrides every other state; the rest follow dout priority.
  assign lfd_go  = ~detect_add & lfd_state;
  assign ld_go   = ~detect_add & ~lfd_state & ld_state;
  assign laf_go  = ~detect_add & ~lfd_state & ~ld_state & laf_state;
  assign cnt_inc = (ld_go & pkt_vld & ~fifo_full) | (laf_go & hold_is_data_q);
  assign acc_en  = lfd_go | cnt_inc;
  assign acc_byte = lfd_go ? header_q : (ld_go ? data_in : hold_q);
  assign addr_ok = {1'b0, data_in[ADDR_W-1:0]} < N_PORTS_W;

  router_chk_accum #(.DATA_W(DATA_W), .CHK_MODE(CHK_MODE)) u_chk_accum (
    .clock  (clock),
    .resetn (resetn),
    .clear  (detect_add),
    .en     (acc_en),
    .byte_in(acc_byte),
    .acc    (acc)
  );

  always_comb begin
    header_d       = header_q;
    hold_d         = hold_q;
    hold_is_data_d = hold_is_data_q;
    pkt_chk_d      = pkt_chk_q;
    pay_cnt_d      = pay_cnt_q;
    ovf_d          = ovf_q;
    dout_d         = dout_q;
    dout_vld_d     = 1'b0;
    lpv_d          = lpv_q;
    pd_d           = pd_q;
    pd_dly_d       = pd_q;
    perr_d         = perr_q;
    lerr_d         = lerr_q;
    err_d          = perr_q | lerr_q;
    bad_addr_d     = bad_addr_q;

    if (detect_add) begin
      if (pkt_vld) begin
        if (addr_ok) begin
          header_d   = data_in;
          bad_addr_d = 1'b0;
        end else begin
          bad_addr_d = 1'b1;
        end
      end
      pay_cnt_d = '0;
      ovf_d     = 1'b0;
      pd_d      = 1'b0;
      perr_d    = 1'b0;
      lerr_d    = 1'b0;
      dout_d    = hold_q;
    end else if (lfd_state) begin
      dout_d     = header_q;
      dout_vld_d = 1'b1;
    end else if (ld_state) begin
      if (fifo_full) begin
        hold_d         = data_in;
        hold_is_data_d = pkt_vld;
      end else begin
        dout_d     = data_in;
        dout_vld_d = 1'b1;
      end
      if (!pkt_vld) begin
        pkt_chk_d = data_in;
        lpv_d     = 1'b1;
        if (!fifo_full) pd_d = 1'b1;
      end
    end else if (laf_state) begin
      dout_d     = hold_q;
      dout_vld_d = 1'b1;
      if (!hold_is_data_q) begin
        pkt_chk_d = hold_q;
        lpv_d     = 1'b1;
      end
      if (lpv_q && !pd_q) pd_d = 1'b1;
    end else if (full_state) begin
      dout_vld_d = 1'b0;
    end

    // A saturated counter cannot represent further bytes; remember that as a length fault.
    if (cnt_inc) begin
      if (pay_cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                      pay_cnt_d = pay_cnt_q + LEN_W'(1);
    end

    if (!detect_add && pd_q && !pd_dly_q) begin
      perr_d = (acc != pkt_chk_q);
      lerr_d = (pay_cnt_q != header_q[DATA_W-1:ADDR_W]) | ovf_q;
    end

    if (rst_int_reg) lpv_d = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_q       <= '0;
      hold_q         <= '0;
      hold_is_data_q <= 1'b0;
      pkt_chk_q      <= '0;
      pay_cnt_q      <= '0;
      ovf_q          <= 1'b0;
      dout_q         <= '0;
      dout_vld_q     <= 1'b0;
      lpv_q          <= 1'b0;
      pd_q           <= 1'b0;
      pd_dly_q       <= 1'b0;
      perr_q         <= 1'b0;
      lerr_q         <= 1'b0;
      err_q          <= 1'b0;
      bad_addr_q     <= 1'b0;
    end else begin
      header_q       <= header_d;
      hold_q         <= hold_d;
      hold_is_data_q <= hold_is_data_d;
      pkt_chk_q      <= pkt_chk_d;
      pay_cnt_q      <= pay_cnt_d;
      ovf_q          <= ovf_d;
      dout_q         <= dout_d;
      dout_vld_q     <= dout_vld_d;
      lpv_q          <= lpv_d;
      pd_q           <= pd_d;
      pd_dly_q       <= pd_dly_d;
      perr_q         <= perr_d;
      lerr_q         <= lerr_d;
      err_q          <= err_d;
      bad_addr_q     <= bad_addr_d;
    end
  end

  assign dout             = dout_q;
  assign dout_vld         = dout_vld_q;
  assign low_packet_valid = lpv_q;
  assign parity_done      = pd_q;
  assign parity_err       = perr_q;
  assign len_err          = lerr_q;
  assign bad_addr         = bad_addr_q;
  assign error            = err_q;

endmodule

// File: tb/tb_router_pkt_register.sv
// Scoreboard bench for router_pkt_register: XOR-check and sum-check instances driven in parallel.
module tb_router_pkt_register;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  logic       clock = 1'b0;
  logic       resetn, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       pkt_vld, fifo_full;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       vld0, vld1, lpv0, lpv1, pd0, pd1, perr0, perr1, lerr0, lerr1, bad0, bad1, err0, err1;

  logic       sel;
  logic [7:0] m_dout;
  logic       m_vld, m_lpv, m_pd, m_perr, m_lerr, m_bad, m_err;

  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];
  logic [2:0] st_q[$];

  always #5 clock = ~clock;

  router_pkt_register #(.DATA_W(8), .ADDR_W(2), .N_PORTS(3), .CHK_MODE(0)) u_xor (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .pkt_vld(pkt_vld), .fifo_full(fifo_full), .data_in(data_in),
    .dout(dout0), .dout_vld(vld0), .low_packet_valid(lpv0), .parity_done(pd0),
    .parity_err(perr0), .len_err(lerr0), .bad_addr(bad0), .error(err0)
  );

  router_pkt_register #(.DATA_W(8), .ADDR_W(2), .N_PORTS(3), .CHK_MODE(1)) u_sum (
    .clock(clock), .resetn(resetn), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .pkt_vld(pkt_vld), .fifo_full(fifo_full), .data_in(data_in),
    .dout(dout1), .dout_vld(vld1), .low_packet_valid(lpv1), .parity_done(pd1),
    .parity_err(perr1), .len_err(lerr1), .bad_addr(bad1), .error(err1)
  );

  assign m_dout = sel ? dout1 : dout0;
  assign m_vld  = sel ? vld1  : vld0;
  assign m_lpv  = sel ? lpv1  : lpv0;
  assign m_pd   = sel ? pd1   : pd0;
  assign m_perr = sel ? perr1 : perr0;
  assign m_lerr = sel ? lerr1 : lerr0;
  assign m_bad  = sel ? bad1  : bad0;
  assign m_err  = sel ? err1  : err0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: bytes are compared as they appear; status two cycles after parity_done rises.
  logic pd_prev = 1'b0;
  int   cd = 0;
  always @(negedge clock) begin
    if (m_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL dout_unexpected: got 0x%0h, expected no output", m_dout);
      end else begin
        check("dout", {24'd0, m_dout}, {24'd0, exp_q.pop_front()});
      end
    end
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (st_q.size() == 0) begin
          checks++;
          $display("FAIL status_unexpected: got %b, expected no check result", {m_perr, m_lerr, m_err});
        end else begin
          check("status{perr,lerr,err}", {29'd0, m_perr, m_lerr, m_err}, {29'd0, st_q.pop_front()});
        end
      end
    end
    if (m_pd === 1'b1 && pd_prev !== 1'b1) cd = 2;
    pd_prev = m_pd;
  end

  task automatic cyc(input logic [5:0] st, input logic pv, input logic ff, input logic [7:0] d);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_vld   = pv;
    fifo_full = ff;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  // pl holds payload bytes little-end first; stall_idx < 0 means no FIFO-full stall.
  task automatic packet(input logic [7:0] hdr, input logic [31:0] pl, input int n,
                        input logic [7:0] chk, input logic [2:0] stat, input int stall_idx);
    logic [7:0] b;
    cyc(S_DA, 1'b1, 1'b0, hdr);
    exp_q.push_back(hdr);
    cyc(S_LFD, 1'b0, 1'b0, hdr);
    for (int i = 0; i < n; i++) begin
      b = pl[8*i +: 8];
      if (i == stall_idx) begin
        cyc(S_LD, 1'b1, 1'b1, b);
        cyc(S_FULL, 1'b1, 1'b1, b);
        exp_q.push_back(b);
        cyc(S_LAF, 1'b1, 1'b0, b);
      end else begin
        exp_q.push_back(b);
        cyc(S_LD, 1'b1, 1'b0, b);
      end
    end
    exp_q.push_back(chk);
    st_q.push_back(stat);
    cyc(S_LD, 1'b0, 1'b0, chk);
    cyc(S_RIR, 1'b0, 1'b0, 8'h00);
    repeat (3) cyc(S_IDLE, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    sel = 1'b0;
    resetn = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
    pkt_vld = 1'b0; fifo_full = 1'b0; data_in = 8'h00;
    #12;
    check("reset_outputs", {16'd0, dout0, vld0, lpv0, pd0, perr0, lerr0, bad0, err0, 1'b0}, 32'd0);
    #1 resetn = 1'b1;
    @(posedge clock); #1;

    // 1: good packet, XOR check
    packet(8'h0D, 32'h00332211, 3, 8'h0D, 3'b000, -1);
    // 2: wrong check byte
    packet(8'h0D, 32'h00332211, 3, 8'h0E, 3'b101, -1);
    // 3: FIFO full while 0x22 is offered
    packet(8'h0D, 32'h00332211, 3, 8'h0D, 3'b000, 1);

    // 4: destination 3 is rejected, header keeps 0x0D
    cyc(S_DA, 1'b1, 1'b0, 8'h0F);
    check("bad_addr_set", {31'd0, m_bad}, 32'd1);
    exp_q.push_back(8'h0D);
    cyc(S_LFD, 1'b0, 1'b0, 8'h0F);
    repeat (2) cyc(S_IDLE, 1'b0, 1'b0, 8'h00);

    // 5: sum check, length field 4 but only 3 payload bytes
    sel = 1'b1;
    packet(8'h11, 32'h00030201, 3, 8'h17, 3'b011, -1);
    check("bad_addr_cleared", {31'd0, m_bad}, 32'd0);
    sel = 1'b0;

    // 6: asynchronous reset mid-payload
    cyc(S_DA, 1'b1, 1'b0, 8'h0D);
    exp_q.push_back(8'h0D);
    cyc(S_LFD, 1'b0, 1'b0, 8'h0D);
    exp_q.push_back(8'h11);
    cyc(S_LD, 1'b1, 1'b0, 8'h11);
    @(negedge clock); #1;
    resetn = 1'b0;
    #1;
    check("async_reset_outputs", {16'd0, dout0, vld0, lpv0, pd0, perr0, lerr0, bad0, err0, 1'b0}, 32'd0);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    packet(8'h0D, 32'h00332211, 3, 8'h0D, 3'b000, -1);

    repeat (3) cyc(S_IDLE, 1'b0, 1'b0, 8'h00);
    check("dout_queue_drained", exp_q.size(), 32'd0);
    check("status_queue_drained", st_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
